// File: rtl/neopixel_rx_pkg.sv
// Shared types and nominal timing for the WS2812 ("neopixel") link.
// Holds the receiver state encoding and the 125 MHz cycle counts that the
// transmitter and receiver both assume.
package neopixel_pkg;

  // Nominal 125 MHz timing shared with the transmitter.
  localparam int unsigned C_T0H_CYCLES        = 50;
  localparam int unsigned C_T1H_CYCLES        = 100;
  localparam int unsigned C_BIT_PERIOD_CYCLES = 156;
  localparam int unsigned C_LATCH_NOM_CYCLES  = 6250;

  // GRB word, G7 first on the wire.
  localparam int unsigned C_BITS_PER_PIXEL = 24;

  // Receiver decode states.
  typedef enum logic [1:0] {
    RX_WAIT_LATCH = 2'd0,
    RX_IDLE       = 2'd1,
    RX_HIGH       = 2'd2,
    RX_LOW        = 2'd3
  } rx_state_t;

endpackage

// File: rtl/neopixel_rx_if.sv
// Neopixel receive bundle: serial line in, decoded pixel/frame results out.
//   neopixel_in  : asynchronous serial line
//   pixel_data   : last complete word, MSB = first bit received
//   pixel_valid  : one-cycle strobe when pixel_data updates
//   pixel_index  : index of pixel_data within the current frame
//   frame_done   : one-cycle strobe at latch detection
//   frame_pixels : complete words in the frame just closed
//   bit_error    : one-cycle strobe on glitch / stuck-high / partial pixel
// master = receiver side, slave = line driver / result consumer.
interface neopixel_rx_if
  import neopixel_pkg::*;
#(
  parameter int unsigned C_BITS_PER_PIXEL = neopixel_pkg::C_BITS_PER_PIXEL
);

  logic                        neopixel_in;
  logic [C_BITS_PER_PIXEL-1:0] pixel_data;
  logic                        pixel_valid;
  logic [15:0]                 pixel_index;
  logic                        frame_done;
  logic [15:0]                 frame_pixels;
  logic                        bit_error;

  modport master (
    input  neopixel_in,
    output pixel_data, pixel_valid, pixel_index,
    output frame_done, frame_pixels, bit_error
  );

  modport slave (
    output neopixel_in,
    input  pixel_data, pixel_valid, pixel_index,
    input  frame_done, frame_pixels, bit_error
  );

endinterface

// File: rtl/neopixel_rx_sync_edge.sv
// Two-flop synchronizer plus history flop and rise/fall detector for one
// asynchronous input. Reusable for any slow asynchronous level.
//   clk, rst   : clock, asynchronous active-high reset
//   async_i    : asynchronous input
//   level_o    : synchronized level (s2)
//   rise_o_c   : combinational rise indication (s2 & ~s3)
//   fall_o_c   : combinational fall indication (~s2 & s3)
module sync_edge
  import neopixel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o_c,
  output logic fall_o_c
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain and history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o  = s2_q;
  assign rise_o_c = s2_q & ~s3_q;
  assign fall_o_c = ~s2_q & s3_q;

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 receive decoder. Measures high-pulse widths on clock_125m,
// classifies bits, assembles GRB words and detects the latch gap.
//   clock_125m : sole clock
//   reset      : asynchronous active-high reset
//   bus        : neopixel_rx_if.master (line in, pixel/frame results out)
module neopixel_rx
  import neopixel_pkg::*;
#(
  parameter int unsigned C_BIT_THRESHOLD  = (C_T0H_CYCLES + C_T1H_CYCLES) / 2,
  parameter int unsigned C_MIN_HIGH       = 20,
  parameter int unsigned C_MAX_HIGH       = 140,
  parameter int unsigned C_LATCH_CYCLES   = C_LATCH_NOM_CYCLES,
  parameter int unsigned C_BITS_PER_PIXEL = neopixel_pkg::C_BITS_PER_PIXEL
)(
  input  logic           clock_125m,
  input  logic           reset,
  neopixel_rx_if.master  bus
);

  localparam int unsigned HCW = $clog2(C_MAX_HIGH + 2);
  localparam int unsigned LCW = $clog2(C_LATCH_CYCLES + 1);
  localparam int unsigned BCW = $clog2(C_BITS_PER_PIXEL + 1);
  localparam int unsigned PW  = C_BITS_PER_PIXEL;

  localparam logic [1:0] S_WAIT_LATCH = RX_WAIT_LATCH;
  localparam logic [1:0] S_IDLE       = RX_IDLE;
  localparam logic [1:0] S_HIGH       = RX_HIGH;
  localparam logic [1:0] S_LOW        = RX_LOW;

  localparam logic [HCW-1:0] HIGH_SAT  = HCW'(C_MAX_HIGH + 1);
  localparam logic [HCW-1:0] HIGH_MAX  = HCW'(C_MAX_HIGH);
  localparam logic [HCW-1:0] HIGH_MIN  = HCW'(C_MIN_HIGH);
  localparam logic [HCW-1:0] HIGH_THR  = HCW'(C_BIT_THRESHOLD);
  localparam logic [LCW-1:0] LOW_LATCH = LCW'(C_LATCH_CYCLES);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(C_BITS_PER_PIXEL - 1);

  logic line;
  logic rise_c;
  logic fall_c;

  logic [1:0]     state_q,        state_d;
  logic [HCW-1:0] high_cnt_q,     high_cnt_d;
  logic [LCW-1:0] low_cnt_q,      low_cnt_d;
  logic [BCW-1:0] bit_cnt_q,      bit_cnt_d;
  logic [15:0]    pix_cnt_q,      pix_cnt_d;
  logic [PW-1:0]  shift_q,        shift_d;
  logic [PW-1:0]  pixel_data_q,   pixel_data_d;
  logic [15:0]    pixel_index_q,  pixel_index_d;
  logic [15:0]    frame_pixels_q, frame_pixels_d;
  logic           pixel_valid_q,  pixel_valid_d;
  logic           frame_done_q,   frame_done_d;
  logic           bit_error_q,    bit_error_d;

  sync_edge u_sync (
    .clk      (clock_125m),
    .rst      (reset),
    .async_i  (bus.neopixel_in),
    .level_o  (line),
    .rise_o_c (rise_c),
    .fall_o_c (fall_c)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clock_125m or posedge reset) begin
    if (reset) begin
      state_q        <= S_WAIT_LATCH;
      high_cnt_q     <= '0;
      low_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      pix_cnt_q      <= '0;
      shift_q        <= '0;
      pixel_data_q   <= '0;
      pixel_index_q  <= '0;
      frame_pixels_q <= '0;
      pixel_valid_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      bit_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      high_cnt_q     <= high_cnt_d;
      low_cnt_q      <= low_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      shift_q        <= shift_d;
      pixel_data_q   <= pixel_data_d;
      pixel_index_q  <= pixel_index_d;
      frame_pixels_q <= frame_pixels_d;
      pixel_valid_q  <= pixel_valid_d;
      frame_done_q   <= frame_done_d;
      bit_error_q    <= bit_error_d;
    end
  end

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d        = state_q;
    high_cnt_d     = high_cnt_q;
    low_cnt_d      = low_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    shift_d        = shift_q;
    pixel_data_d   = pixel_data_q;
    pixel_index_d  = pixel_index_q;
    frame_pixels_d = frame_pixels_q;
    pixel_valid_d  = 1'b0;
    frame_done_d   = 1'b0;
    bit_error_d    = 1'b0;

    case (state_q)
      // Resynchronise: need an unbroken low of latch length, no frame_done.
      S_WAIT_LATCH: begin
        if (line) begin
          low_cnt_d = '0;
        end else if (low_cnt_q >= LOW_LATCH) begin
          low_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          low_cnt_d = low_cnt_q + LCW'(1);
        end
      end

      S_IDLE: begin
        if (rise_c) begin
          high_cnt_d = HCW'(1);
          state_d    = S_HIGH;
        end
      end

      S_HIGH: begin
        if (high_cnt_q > HIGH_MAX) begin
          // Stuck high: drop partial word and frame progress.
          bit_error_d = 1'b1;
          bit_cnt_d   = '0;
          pix_cnt_d   = '0;
          low_cnt_d   = '0;
          state_d     = S_WAIT_LATCH;
        end else if (fall_c) begin
          low_cnt_d = LCW'(1);
          state_d   = S_LOW;
          if (high_cnt_q < HIGH_MIN) begin
            bit_error_d = 1'b1;
          end else begin
            shift_d = {shift_q[PW-2:0], (high_cnt_q >= HIGH_THR)};
            if (bit_cnt_q == BIT_LAST) begin
              pixel_data_d  = shift_d;
              pixel_valid_d = 1'b1;
              pixel_index_d = pix_cnt_q;
              if (pix_cnt_q != 16'hFFFF) begin
                pix_cnt_d = pix_cnt_q + 16'd1;
              end
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
        end else if (high_cnt_q != HIGH_SAT) begin
          high_cnt_d = high_cnt_q + HCW'(1);
        end
      end

      S_LOW: begin
        if (rise_c) begin
          high_cnt_d = HCW'(1);
          state_d    = S_HIGH;
        end else if (low_cnt_q >= LOW_LATCH) begin
          // Latch: close frame; a partial word is reported and dropped.
          frame_done_d   = 1'b1;
          frame_pixels_d = pix_cnt_q;
          bit_error_d    = (bit_cnt_q != '0);
          bit_cnt_d      = '0;
          pix_cnt_d      = '0;
          low_cnt_d      = '0;
          state_d        = S_IDLE;
        end else begin
          low_cnt_d = low_cnt_q + LCW'(1);
        end
      end

      default: begin
        state_d = S_WAIT_LATCH;
      end
    endcase
  end

  assign bus.pixel_data   = pixel_data_q;
  assign bus.pixel_valid  = pixel_valid_q;
  assign bus.pixel_index  = pixel_index_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_pixels = frame_pixels_q;
  assign bus.bit_error    = bit_error_q;

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: drives the serial line with exact-width
// pulses and checks pixel words, indices, frame counts and error strobes.
module tb_neopixel_rx;
  import neopixel_pkg::*;

  localparam bit          C_SIM_MODE = 1'b1;
  localparam int unsigned C_LATCH    = C_SIM_MODE ? 300 : C_LATCH_NOM_CYCLES;
  localparam int unsigned C_GAP      = C_LATCH + 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  neopixel_rx_if bus ();

  neopixel_rx #(
    .C_BIT_THRESHOLD  (75),
    .C_MIN_HIGH       (20),
    .C_MAX_HIGH       (140),
    .C_LATCH_CYCLES   (C_LATCH),
    .C_BITS_PER_PIXEL (24)
  ) dut (
    .clock_125m (clk),
    .reset      (rst),
    .bus        (bus)
  );

  // Event monitor sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned pv_cnt = 0, fd_cnt = 0, be_cnt = 0, bf_cnt = 0;
  int unsigned overlap_cnt = 0, wide_cnt = 0, be_cyc = 0;
  logic [15:0] fp_last = '0;
  logic        prev_pv = 1'b0, prev_fd = 1'b0, prev_be = 1'b0;
  logic [23:0] pv_data[$];
  logic [15:0] pv_idx[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_pv <= bus.pixel_valid;
    prev_fd <= bus.frame_done;
    prev_be <= bus.bit_error;
    if (bus.pixel_valid) begin
      pv_cnt <= pv_cnt + 1;
      pv_data.push_back(bus.pixel_data);
      pv_idx.push_back(bus.pixel_index);
    end
    if (bus.frame_done) begin
      fd_cnt  <= fd_cnt + 1;
      fp_last <= bus.frame_pixels;
    end
    if (bus.bit_error) begin
      be_cnt <= be_cnt + 1;
      be_cyc <= cyc;
    end
    if (bus.bit_error && bus.frame_done) bf_cnt <= bf_cnt + 1;
    if (bus.pixel_valid && bus.frame_done) overlap_cnt <= overlap_cnt + 1;
    if ((bus.pixel_valid && prev_pv) || (bus.frame_done && prev_fd) ||
        (bus.bit_error && prev_be)) wide_cnt <= wide_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] data_at(input int unsigned k);
    if (k < pv_data.size()) return pv_data[k];
    return 'x;
  endfunction

  function automatic logic [15:0] idx_at(input int unsigned k);
    if (k < pv_idx.size()) return pv_idx[k];
    return 'x;
  endfunction

  // Each task starts and ends at a falling edge.
  task automatic send_bit(input int unsigned h);
    bus.neopixel_in = 1'b1;
    repeat (h) @(negedge clk);
    bus.neopixel_in = 1'b0;
    repeat (C_BIT_PERIOD_CYCLES - h) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] d);
    for (int i = 23; i >= 0; i--) send_bit(d[i] ? C_T1H_CYCLES : C_T0H_CYCLES);
  endtask

  task automatic idle_low(input int unsigned n);
    bus.neopixel_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int unsigned pv0, fd0, be0, bf0, c0;
  logic [23:0] exp4 [4];

  initial begin
    exp4[0] = 24'h000000;
    exp4[1] = 24'hFFFFFF;
    exp4[2] = 24'h123456;
    exp4[3] = 24'h800001;

    // Reset state.
    bus.neopixel_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pixel_data", 32'(bus.pixel_data), 32'h0);
    check("rst_strobes", {29'd0, bus.pixel_valid, bus.frame_done, bus.bit_error}, 32'h0);
    check("rst_index_fp", {bus.pixel_index, bus.frame_pixels}, 32'h0);
    rst = 1'b0;

    // Initial latch wait: no frame_done for the resync gap.
    idle_low(C_GAP);
    check("resync_no_fd", fd_cnt, 0);

    // Single nominal pixel then latch.
    pv0 = pv_cnt; fd0 = fd_cnt; be0 = be_cnt;
    send_pixel(24'hA53C0F);
    idle_low(C_GAP);
    check("t1_pv_count", pv_cnt - pv0, 1);
    check("t1_data", 32'(data_at(pv0)), 32'hA53C0F);
    check("t1_index", 32'(idx_at(pv0)), 32'h0);
    check("t1_fd_count", fd_cnt - fd0, 1);
    check("t1_frame_pixels", 32'(fp_last), 32'd1);
    check("t1_no_err", be_cnt - be0, 0);
    check("t1_hold_data", 32'(bus.pixel_data), 32'hA53C0F);

    // Four-pixel frame.
    pv0 = pv_cnt; fd0 = fd_cnt;
    for (int k = 0; k < 4; k++) send_pixel(exp4[k]);
    idle_low(C_GAP);
    check("t2_pv_count", pv_cnt - pv0, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_data%0d", k), 32'(data_at(pv0 + k)), 32'(exp4[k]));
      check($sformatf("t2_index%0d", k), 32'(idx_at(pv0 + k)), k);
    end
    check("t2_fd_count", fd_cnt - fd0, 1);
    check("t2_frame_pixels", 32'(fp_last), 32'd4);

    // Threshold / min / max boundaries with a mid-word glitch.
    pv0 = pv_cnt; fd0 = fd_cnt; be0 = be_cnt;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) send_bit(10);
      if (i == 0)       send_bit(20);
      else if (i == 23) send_bit(140);
      else              send_bit((i % 2) ? 75 : 74);
    end
    idle_low(C_GAP);
    check("t3_pv_count", pv_cnt - pv0, 1);
    check("t3_data", 32'(data_at(pv0)), 32'h555555);
    check("t3_index", 32'(idx_at(pv0)), 32'h0);
    check("t3_glitch_err", be_cnt - be0, 1);
    check("t3_fd_count", fd_cnt - fd0, 1);
    check("t3_frame_pixels", 32'(fp_last), 32'd1);

    // Stuck high mid-word, then ignored bits until a full latch gap.
    pv0 = pv_cnt; fd0 = fd_cnt; be0 = be_cnt;
    for (int i = 0; i < 5; i++) send_bit(C_T1H_CYCLES);
    c0 = cyc;
    bus.neopixel_in = 1'b1;
    repeat (200) @(negedge clk);
    idle_low(20);
    check("t4_stuck_err", be_cnt - be0, 1);
    check("t4_stuck_delay", 32'((be_cyc - c0 >= 140) && (be_cyc - c0 <= 150)), 32'd1);
    send_pixel(24'hFFFFFF);
    idle_low(C_GAP);
    check("t4_ignored_pv", pv_cnt - pv0, 0);
    check("t4_no_fd", fd_cnt - fd0, 0);
    check("t4_single_err", be_cnt - be0, 1);
    send_pixel(24'h0F0F0F);
    idle_low(C_GAP);
    check("t4_recover_data", 32'(data_at(pv0)), 32'h0F0F0F);
    check("t4_recover_index", 32'(idx_at(pv0)), 32'h0);
    check("t4_recover_fp", 32'(fp_last), 32'd1);

    // Partial pixel at latch.
    pv0 = pv_cnt; fd0 = fd_cnt; be0 = be_cnt; bf0 = bf_cnt;
    for (int i = 0; i < 12; i++) send_bit(C_T0H_CYCLES);
    idle_low(C_GAP);
    check("t5_fd_count", fd_cnt - fd0, 1);
    check("t5_err_count", be_cnt - be0, 1);
    check("t5_err_with_fd", bf_cnt - bf0, 1);
    check("t5_frame_pixels", 32'(fp_last), 32'd0);
    check("t5_no_pv", pv_cnt - pv0, 0);

    // Reset mid-frame, then a pixel with no latch gap is ignored.
    for (int i = 0; i < 20; i++) send_bit(C_T1H_CYCLES);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_data", 32'(bus.pixel_data), 32'h0);
    check("t6_rst_index_fp", {bus.pixel_index, bus.frame_pixels}, 32'h0);
    rst = 1'b0;
    pv0 = pv_cnt; fd0 = fd_cnt; be0 = be_cnt;
    send_pixel(24'h123456);
    idle_low(C_GAP);
    check("t6_ignored_pv", pv_cnt - pv0, 0);
    check("t6_ignored_fd", fd_cnt - fd0, 0);
    check("t6_ignored_err", be_cnt - be0, 0);
    send_pixel(24'h5AC3E1);
    idle_low(C_GAP);
    check("t6_pv_count", pv_cnt - pv0, 1);
    check("t6_data", 32'(data_at(pv0)), 32'h5AC3E1);
    check("t6_index", 32'(idx_at(pv0)), 32'h0);
    check("t6_fd_count", fd_cnt - fd0, 1);
    check("t6_frame_pixels", 32'(fp_last), 32'd1);

    // Global strobe properties.
    check("pv_fd_overlap", overlap_cnt, 0);
    check("strobe_width", wide_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neopixel_rx.md
# neopixel_rx

Receive-side decoder for the single-wire WS2812 ("neopixel") link driven by `top` on `neopixel_drive`. It measures high-pulse widths on the `clock_125m` domain, classifies each bit as 0 or 1, and assembles 24-bit GRB pixel words. It detects the latch (reset) gap that ends a frame. It serves as a self-checking monitor in simulation and as a loopback checker on the board.

## Interface
- `C_BIT_THRESHOLD`, 75: high width in clocks at or above which a bit decodes as 1. Nominal widths are 50 for a 0 and 100 for a 1.
- `C_MIN_HIGH`, 20: high width in clocks below which a pulse counts as a glitch.
- `C_MAX_HIGH`, 140: high width in clocks above which the line counts as stuck high.
- `C_LATCH_CYCLES`, 6250: low time in clocks that marks a latch (50 µs). The bench sets this lower in `C_SIM_MODE`.
- `C_BITS_PER_PIXEL`, 24: bits per pixel word.

- `clock_125m`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `neopixel_in`, in, 1: asynchronous serial line.
- `pixel_data`, out, `C_BITS_PER_PIXEL`: last complete word, MSB = first bit received (G7).
- `pixel_valid`, out, 1: one-cycle strobe when `pixel_data` updates.
- `pixel_index`, out, 16: index of the word on `pixel_data` within the current frame, starting at 0.
- `frame_done`, out, 1: one-cycle strobe at latch detection.
- `frame_pixels`, out, 16: number of complete words in the frame just closed. Valid with `frame_done`.
- `bit_error`, out, 1: one-cycle strobe on glitch, stuck-high or partial-pixel condition.

## Operation
- Input path: two-flop synchronizer `s1`→`s2`, then history flop `s3`.
  - rise = `s2 & ~s3`; fall = `~s2 & s3`.
- States and transitions:
  - WAIT_LATCH: entered from reset and after stuck-high. Bits are ignored. Low counter runs while `s2`=0 and clears when `s2`=1. When the count reaches `C_LATCH_CYCLES`, go to IDLE with no `frame_done`.
  - IDLE: on rise, go to HIGH.
  - HIGH: high counter increments each cycle.
    - Counter exceeds `C_MAX_HIGH`: pulse `bit_error`, discard the partial word, clear the bit and pixel counters, go to WAIT_LATCH.
    - Fall: classify the pulse, then go to LOW.
  - LOW: low counter increments.
    - Rise: go to HIGH.
    - Low count reaches `C_LATCH_CYCLES`: pulse `frame_done` with `frame_pixels` = pixel counter, clear the counters, go to IDLE.
- Classification at fall:
  - Width < `C_MIN_HIGH`: pulse `bit_error` and discard the bit. The bit counter is unchanged.
  - Otherwise: shift left, LSB = (width ≥ `C_BIT_THRESHOLD`), and increment the bit counter.
  - When the bit counter reaches `C_BITS_PER_PIXEL`:
    - load `pixel_data` and pulse `pixel_valid`;
    - set `pixel_index` = pixel counter, then increment the pixel counter (saturating at 65535);
    - clear the bit counter.
- Latch with bit counter ≠ 0: pulse `bit_error` in the same cycle as `frame_done`. The partial word is dropped and `frame_pixels` excludes it.
- Counters:
  - high counter is `$clog2(C_MAX_HIGH+2)` bits wide;
  - low counter is `$clog2(C_LATCH_CYCLES+1)` bits wide;
  - both saturate and never wrap.

## Timing
- Reset values (asynchronous):
  - all outputs 0;
  - state WAIT_LATCH;
  - synchronizer flops 0;
  - counters and shift register 0.
- Reset mid-frame: immediate return to WAIT_LATCH; no strobes are emitted.
- Edge-detect latency: an input transition is first sampled at clock edge N; rise/fall is seen combinationally in cycle N+2.
- Output latency: all outputs are registered. `pixel_valid`, `bit_error` and the stuck-high `bit_error` are visible at N+3. `frame_done` is visible 3 cycles after the low count reaches threshold.
- Measured widths: high width equals the input high width in clocks, ±1 for sampling phase. `frame_done` follows the last fall by `C_LATCH_CYCLES`+1 cycles.
- Strobes are one cycle wide. `pixel_valid` and `frame_done` are never asserted in the same cycle.
- `pixel_data`, `pixel_index` and `frame_pixels` hold their values between strobes.

## Structure
- Package `neopixel_pkg` holds:
  - the state enum `rx_state_t`;
  - the nominal timing constants shared with the transmitter (T0H = 50, T1H = 100, bit period = 156, latch = 6250 cycles at 125 MHz);
  - `C_BITS_PER_PIXEL`.
- Sub-module `sync_edge`: 2-flop synchronizer plus rise/fall detector. It is reusable for other asynchronous inputs.

## Test plan
- Reset, then a 6250-cycle low, then pixel 0xA5_3C_0F with nominal 50/100-cycle highs in 156-cycle periods, then a latch. Expect:
  - `pixel_valid` once, with `pixel_data` = 0xA53C0F and `pixel_index` = 0;
  - `frame_done` with `frame_pixels` = 1.
- Loopback of `top` with `C_PIXEL_COUNT` = 4 and a reduced latch. Expect 4 `pixel_valid` strobes with indices 0..3, then `frame_done` with `frame_pixels` = 4, repeating each control period.
- Threshold boundaries with no latch gap in between, then a latch:
  - high widths of 74 and 75 cycles decode as 0 and 1;
  - a width-10 glitch inserted mid-word gives `bit_error` and the word still completes correctly after 24 valid bits.
- Line held high for 200 cycles mid-word. Expect `bit_error` about 144 cycles after the rise and no `pixel_valid`. Later bits are ignored until 6250 low cycles have elapsed.
- 12 bits, then a latch. Expect `frame_done` and `bit_error` in the same cycle, `frame_pixels` = 0, and no `pixel_valid`.
- `reset` asserted after 20 bits, released, then a full pixel sent without a latch gap. Expect no output until a latch is seen; the following frame decodes correctly.
